// File: rtl/svo_tmds_enc_pkg.sv
// Shared constants and helpers for the TMDS/HDMI channel encoder:
// mode encodings, control tokens, TERC4 symbols, guard-band words and popcount.
package svo_tmds_pkg;

    // Shared mode select encodings
    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_DATA   = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    // Control-period tokens, indexed by {C1,C0}; bit0 is transmitted first
    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    // Guard-band words: pattern A on lanes 0/2 (mod 3), pattern B on lane 1
    localparam logic [9:0] GUARD_PAT_A = 10'h0CD;
    localparam logic [9:0] GUARD_PAT_B = 10'h332;

    // TERC4 symbols indexed by the 4-bit data nibble, stored as dout[9:0]
    // (the published table lists q_out[0:9], so each entry is bit-reversed)
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'h0E5, 10'h319, 10'h09D, 10'h11D,
        10'h23A, 10'h1E2, 10'h1C6, 10'h0F2,
        10'h0CD, 10'h272, 10'h0E6, 10'h18D,
        10'h1C5, 10'h239, 10'h31A, 10'h30D
    };

    // Stage-2 DC-balance decision for a video symbol
    typedef enum logic [1:0] {
        DC_NEUTRAL,
        DC_INVERT,
        DC_PASS
    } dc_case_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_TOKEN_00;
            2'b01:   t = CTRL_TOKEN_01;
            2'b10:   t = CTRL_TOKEN_10;
            default: t = CTRL_TOKEN_11;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] nib);
        return TERC4_TABLE[nib];
    endfunction

endpackage

// File: rtl/svo_tmds_enc_lane.sv
// One TMDS lane: mode multiplexer, DVI 8b/10b encoder with running disparity,
// and the encode register that feeds the shared retiming chain.
module svo_tmds_lane
    import svo_tmds_pkg::*;
#(
    parameter int unsigned LANE_IDX = 0
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [2:0] i_mode,
    input  logic [1:0] i_ctrl,
    input  logic [7:0] i_din,
    input  logic [3:0] i_aux,
    output logic [9:0] o_sym
);

    localparam int unsigned GUARD_PHASE = LANE_IDX % 3;

    logic [3:0]        w_din_ones;
    logic              w_use_xnor;
    logic [8:0]        w_qm;
    logic [3:0]        w_qm_ones;
    logic signed [5:0] w_qm_bal;
    dc_case_e          w_dc_case;
    logic [9:0]        w_video_sym;
    logic signed [5:0] w_cnt_next;
    logic [9:0]        w_sym;
    logic signed [5:0] r_cnt;
    logic [9:0]        r_sym;

    assign w_din_ones = popcount8(i_din);
    assign w_use_xnor = (w_din_ones > 4'd4) || ((w_din_ones == 4'd4) && !i_din[0]);

    // Transition minimisation: chain each input bit through XOR or XNOR
    always_comb begin : qm_chain
        logic [8:0] v_qm;
        v_qm    = '0;
        v_qm[0] = i_din[0];
        for (int unsigned i = 1; i < 8; i++) begin
            v_qm[i] = w_use_xnor ? ~(v_qm[i-1] ^ i_din[i]) : (v_qm[i-1] ^ i_din[i]);
        end
        v_qm[8] = ~w_use_xnor;
        w_qm    = v_qm;
    end

    // N1q - N0q over q_m[7:0], i.e. 2*ones - 8, range -8..+8
    assign w_qm_ones = popcount8(w_qm[7:0]);
    assign w_qm_bal  = $signed({1'b0, w_qm_ones, 1'b0}) - 6'sd8;

    // Select the DC-balance case; with both values non-zero, matching signs mean invert
    always_comb begin
        w_dc_case = DC_PASS;
        if ((r_cnt == 6'sd0) || (w_qm_bal == 6'sd0)) begin
            w_dc_case = DC_NEUTRAL;
        end else if (r_cnt[5] == w_qm_bal[5]) begin
            w_dc_case = DC_INVERT;
        end
    end

    // Form the video symbol and the updated running disparity
    always_comb begin
        w_video_sym = '0;
        w_cnt_next  = r_cnt;
        case (w_dc_case)
            DC_NEUTRAL: begin
                w_video_sym = {~w_qm[8], w_qm[8], (w_qm[8] ? w_qm[7:0] : ~w_qm[7:0])};
                w_cnt_next  = w_qm[8] ? (r_cnt + w_qm_bal) : (r_cnt - w_qm_bal);
            end
            DC_INVERT: begin
                w_video_sym = {1'b1, w_qm[8], ~w_qm[7:0]};
                w_cnt_next  = r_cnt + (w_qm[8] ? 6'sd2 : 6'sd0) - w_qm_bal;
            end
            default: begin
                w_video_sym = {1'b0, w_qm[8], w_qm[7:0]};
                w_cnt_next  = r_cnt - (w_qm[8] ? 6'sd0 : 6'sd2) + w_qm_bal;
            end
        endcase
    end

    // Per-mode symbol selection; illegal modes fall back to control tokens
    always_comb begin
        w_sym = ctrl_token(i_ctrl);
        case (i_mode)
            MODE_CTRL:   w_sym = ctrl_token(i_ctrl);
            MODE_VIDEO:  w_sym = w_video_sym;
            MODE_VGUARD: w_sym = (GUARD_PHASE == 1) ? GUARD_PAT_B : GUARD_PAT_A;
            MODE_DATA:   w_sym = terc4(i_aux);
            MODE_DGUARD: w_sym = (LANE_IDX == 0) ? terc4({2'b11, i_ctrl}) : GUARD_PAT_B;
            default:     w_sym = ctrl_token(i_ctrl);
        endcase
    end

    // Encode register and disparity counter; any non-video symbol clears the counter
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sym <= CTRL_TOKEN_00;
            r_cnt <= '0;
        end else begin
            r_sym <= w_sym;
            r_cnt <= (i_mode == MODE_VIDEO) ? w_cnt_next : '0;
        end
    end

    assign o_sym = r_sym;

endmodule

// File: rtl/svo_tmds_enc.sv
// Multi-lane TMDS/HDMI channel encoder: CHANNELS encoder lanes sharing one mode
// select, followed by a PIPE_STAGES-deep retiming chain and a sticky mode error flag.
module svo_tmds_enc
    import svo_tmds_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [2:0]              mode,
    input  logic [2*CHANNELS-1:0]   ctrl,
    input  logic [8*CHANNELS-1:0]   din,
    input  logic [4*CHANNELS-1:0]   aux,
    output logic [10*CHANNELS-1:0]  dout,
    output logic                    mode_err
);

    localparam logic [10*CHANNELS-1:0] RESET_WORD = {CHANNELS{CTRL_TOKEN_00}};

    logic [10*CHANNELS-1:0] w_enc;
    logic                   r_mode_err;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        svo_tmds_lane #(
            .LANE_IDX (gi)
        ) u_lane (
            .i_clk    (clk),
            .i_resetn (resetn),
            .i_mode   (mode),
            .i_ctrl   (ctrl[2*gi +: 2]),
            .i_din    (din[8*gi +: 8]),
            .i_aux    (aux[4*gi +: 4]),
            .o_sym    (w_enc[10*gi +: 10])
        );
    end

    if (PIPE_STAGES == 0) begin : g_no_pipe
        assign dout = w_enc;
    end else begin : g_pipe
        logic [10*CHANNELS-1:0] r_pipe [PIPE_STAGES];

        // Retiming delay chain; every stage resets to the CTRL 00 token on all lanes
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                    r_pipe[s] <= RESET_WORD;
                end
            end else begin
                r_pipe[0] <= w_enc;
                for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        assign dout = r_pipe[PIPE_STAGES-1];
    end

    // Sticky flag for any sampled mode above DGUARD; only reset clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode_err <= 1'b0;
        end else if (mode > MODE_DGUARD) begin
            r_mode_err <= 1'b1;
        end
    end

    assign mode_err = r_mode_err;

endmodule

// File: tb/tb_svo_tmds_enc.sv
// Directed bench for svo_tmds_enc: a 4-lane, 2-stage instance and a 1-lane,
// zero-stage instance share stimulus; an independent lane model feeds a
// scoreboard queue that is popped as each symbol leaves the pipeline.
module tb_svo_tmds_enc;

    localparam int unsigned CH = 4;
    localparam int unsigned PS = 2;
    localparam int unsigned W  = 10 * CH;
    localparam logic [9:0]  TOK00 = 10'h354;
    localparam logic [W-1:0] M0   = 40'h00_0000_03FF;
    localparam logic [W-1:0] MALL = {W{1'b1}};

    logic           clk = 1'b0;
    logic           resetn;
    logic [2:0]     mode;
    logic [2*CH-1:0] ctrl;
    logic [8*CH-1:0] din;
    logic [4*CH-1:0] aux;
    logic [W-1:0]   dout_a;
    logic           mode_err_a;
    logic [9:0]     dout_b;
    logic           mode_err_b;

    svo_tmds_enc #(.CHANNELS(CH), .PIPE_STAGES(PS)) dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .mode     (mode),
        .ctrl     (ctrl),
        .din      (din),
        .aux      (aux),
        .dout     (dout_a),
        .mode_err (mode_err_a)
    );

    svo_tmds_enc #(.CHANNELS(1), .PIPE_STAGES(0)) dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .mode     (mode),
        .ctrl     (ctrl[1:0]),
        .din      (din[7:0]),
        .aux      (aux[3:0]),
        .dout     (dout_b),
        .mode_err (mode_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        logic [W-1:0] sval;
        logic [W-1:0] smask;
        string        tag;
    } sb_t;

    sb_t        q_a[$];
    logic [9:0] q_b[$];

    int checks = 0;
    int errors = 0;

    logic signed [5:0] m_cnt [CH];
    logic              m_err;

    logic [9:0] terc_tab [16] = '{
        10'h0E5, 10'h319, 10'h09D, 10'h11D, 10'h23A, 10'h1E2, 10'h1C6, 10'h0F2,
        10'h0CD, 10'h272, 10'h0E6, 10'h18D, 10'h1C5, 10'h239, 10'h31A, 10'h30D
    };
    logic [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic logic [9:0] model_lane(input int lane, input logic [2:0] m,
                                              input logic [1:0] c, input logic [7:0] d,
                                              input logic [3:0] a, input logic signed [5:0] cin,
                                              output logic signed [5:0] cout);
        int         cnt, n1, n1q, n0q, q8;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] sym;
        logic [3:0] g;
        cout = '0;
        sym  = '0;
        case (m)
            3'd1: begin
                cnt = int'(cin);
                n1  = $countones(d);
                xn  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++)
                    qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
                qm[8] = ~xn;
                q8  = int'(qm[8]);
                n1q = $countones(qm[7:0]);
                n0q = 8 - n1q;
                if (cnt == 0 || n1q == n0q) begin
                    sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                    cnt = cnt + ((q8 == 1) ? (n1q - n0q) : (n0q - n1q));
                end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
                    sym = {1'b1, qm[8], ~qm[7:0]};
                    cnt = cnt + 2 * q8 + (n0q - n1q);
                end else begin
                    sym = {1'b0, qm[8], qm[7:0]};
                    cnt = cnt - 2 * (1 - q8) + (n1q - n0q);
                end
                cout = cnt[5:0];
            end
            3'd2: sym = (lane % 3 == 1) ? 10'h332 : 10'h0CD;
            3'd3: sym = terc_tab[a];
            3'd4: begin
                g   = {2'b11, c};
                sym = (lane == 0) ? terc_tab[g] : 10'h332;
            end
            default: sym = ctrl_tab[c];
        endcase
        return sym;
    endfunction

    function automatic logic [W-1:0] lanes(input logic [9:0] l3, input logic [9:0] l2,
                                           input logic [9:0] l1, input logic [9:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one symbol's inputs at the falling edge, score what leaves after the rising edge
    task automatic drive(input string tag, input logic [2:0] m, input logic [7:0] c,
                         input logic [31:0] d, input logic [15:0] a,
                         input logic [W-1:0] sval, input logic [W-1:0] smask);
        sb_t               e;
        sb_t               got;
        logic [9:0]        eb;
        logic signed [5:0] nc;
        mode = m;
        ctrl = c;
        din  = d;
        aux  = a;
        for (int i = 0; i < CH; i++) begin
            e.exp[10*i +: 10] = model_lane(i, m, c[2*i +: 2], d[8*i +: 8], a[4*i +: 4], m_cnt[i], nc);
            m_cnt[i] = nc;
        end
        e.sval  = sval;
        e.smask = smask;
        e.tag   = tag;
        q_a.push_back(e);
        q_b.push_back(e.exp[9:0]);
        if (m > 3'd4) m_err = 1'b1;
        @(posedge clk);
        #1;
        got = q_a.pop_front();
        eb  = q_b.pop_front();
        check({got.tag, "/dout"}, 64'(dout_a), 64'(got.exp));
        if (got.smask != '0)
            check({got.tag, "/spot"}, 64'(dout_a & got.smask), 64'(got.sval & got.smask));
        check({tag, "/dout_p0"}, 64'(dout_b), 64'(eb));
        check({tag, "/mode_err"}, {62'b0, mode_err_a, mode_err_b}, {62'b0, m_err, m_err});
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle, released on a falling edge
    task automatic apply_reset(input string tag);
        sb_t e;
        #2 resetn = 1'b0;
        #1;
        check({tag, "/async_dout"}, 64'(dout_a), 64'({CH{TOK00}}));
        check({tag, "/async_dout_p0"}, 64'(dout_b), 64'(TOK00));
        check({tag, "/async_err"}, {62'b0, mode_err_a, mode_err_b}, 64'd0);
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < CH; i++) m_cnt[i] = '0;
        m_err = 1'b0;
        for (int s = 0; s < PS; s++) begin
            e.exp   = {CH{TOK00}};
            e.sval  = e.exp;
            e.smask = MALL;
            e.tag   = {tag, "_fill"};
            q_a.push_back(e);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        mode   = 3'd0;
        ctrl   = '0;
        din    = '0;
        aux    = '0;
        m_err  = 1'b0;
        for (int i = 0; i < CH; i++) m_cnt[i] = '0;

        apply_reset("por");

        // Control tokens; lane 1 = 01 must appear exactly three symbols later
        drive("ctrl_l1_01", 3'd0, 8'h04, '0, '0, lanes(10'h354, 10'h354, 10'h0AB, 10'h354), MALL);
        drive("ctrl_all",   3'd0, 8'hE4, '0, '0, lanes(10'h2AB, 10'h154, 10'h0AB, 10'h354), MALL);

        // Video 0xFF on lane 0 from cnt=0: 200, 0FF, 0FF, 200
        drive("vid_ff0", 3'd1, '0, 32'h10A5_3CFF, '0, 40'h200, M0);
        drive("vid_ff1", 3'd1, '0, 32'h10A5_3CFF, '0, 40'h0FF, M0);
        drive("vid_ff2", 3'd1, '0, 32'h10A5_3CFF, '0, 40'h0FF, M0);
        drive("vid_ff3", 3'd1, '0, 32'h10A5_3CFF, '0, 40'h200, M0);
        drive("vid_brk", 3'd0, '0, '0, '0, '0, '0);

        // Video 0x00 stream; first word from cnt=0 is 100
        drive("vid_00_0", 3'd1, '0, 32'h0000_0000, '0, 40'h100, M0);
        for (int k = 0; k < 5; k++)
            drive("vid_00_n", 3'd1, '0, 32'h0000_0000, '0, '0, '0);

        // One control symbol restarts disparity: 0xFF gives 200 again
        drive("ctrl_gap",  3'd0, '0, '0, '0, '0, '0);
        drive("vid_rest",  3'd1, '0, 32'hFFFF_FFFF, '0, lanes(10'h200, 10'h200, 10'h200, 10'h200), MALL);

        // Pseudo-random video stream exercising all three disparity cases
        for (int k = 0; k < 24; k++)
            drive("vid_rand", 3'd1, '0, 32'($urandom()), '0, '0, '0);

        // TERC4 data islands across every nibble
        drive("data_0",    3'd3, '0, '0, 16'h0000, lanes(10'h0E5, 10'h0E5, 10'h0E5, 10'h0E5), MALL);
        drive("data_3210", 3'd3, '0, '0, 16'h3210, lanes(10'h11D, 10'h09D, 10'h319, 10'h0E5), MALL);
        drive("data_7654", 3'd3, '0, '0, 16'h7654, '0, '0);
        drive("data_ba98", 3'd3, '0, '0, 16'hBA98, '0, '0);
        drive("data_fedc", 3'd3, '0, '0, 16'hFEDC, lanes(10'h30D, 10'h31A, 10'h239, 10'h1C5), MALL);

        // Data-island and video guard bands
        drive("dguard_00", 3'd4, 8'h00, '0, '0, lanes(10'h332, 10'h332, 10'h332, 10'h1C5), MALL);
        drive("dguard_11", 3'd4, 8'h03, '0, '0, lanes(10'h332, 10'h332, 10'h332, 10'h30D), MALL);
        drive("vguard",    3'd2, '0, '0, '0, lanes(10'h0CD, 10'h0CD, 10'h332, 10'h0CD), MALL);

        // Video straight out of a guard band starts from cnt=0
        drive("vid_after_g", 3'd1, '0, 32'h00FF_00FF, '0, 40'h200, M0);

        // Illegal modes encode as control and latch mode_err
        drive("illegal_6", 3'd6, 8'h02, 32'hFFFF_FFFF, '0, 40'h154, M0);
        drive("legal_vid", 3'd1, '0, 32'h1234_5678, '0, '0, '0);
        drive("illegal_5", 3'd5, 8'hFF, '0, '0, lanes(10'h2AB, 10'h2AB, 10'h2AB, 10'h2AB), MALL);
        drive("illegal_7", 3'd7, 8'h1B, '0, '0, '0, '0);
        drive("legal_data", 3'd3, '0, '0, 16'h5A5A, '0, '0);

        // Reset in mid-stream clears outputs, disparity and the error flag
        drive("pre_rst_vid", 3'd1, '0, 32'hC3C3_C3C3, '0, '0, '0);
        apply_reset("mid");
        drive("post_rst_c", 3'd0, 8'h04, '0, '0, lanes(10'h354, 10'h354, 10'h0AB, 10'h354), MALL);
        drive("post_rst_v", 3'd1, '0, 32'hFFFF_FFFF, '0, 40'h200, M0);
        for (int k = 0; k < 6; k++)
            drive("post_rst_r", 3'd1, '0, 32'($urandom()), '0, '0, '0);

        // Flush the retiming chain so every queued symbol is scored
        for (int k = 0; k <= int'(PS); k++)
            drive("flush", 3'd0, '0, '0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
